// File: rtl/ks_level5_sum.sv
// ks_level5_sum: level-5 Kogge-Stone merge, sum/flags and valid/ready output slot.
// Define KS_SKID_EN to add a skid entry and register in_ready.
module ks_level5_sum #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:16]     p_list4,
  input  logic [31:4]      g_list4,
  input  logic [3:0]       g_lo,
  input  logic [31:0]      hp,
  input  logic             cin,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HOLD1 = 2'd1;
`ifdef KS_SKID_EN
  localparam logic [1:0] HOLD2 = 2'd2;
`endif
  logic [15:0] g_low;
  logic [31:0] g;
  logic [31:0] sum_d;
  logic [1:0]  state, nxt;
  logic        in_fire;
  // carries below bit 16 are already complete; only the upper half needs the span-16 grey cell
  assign g_low     = {g_list4[15:4], g_lo};
  assign g         = {g_list4[31:16] | (p_list4 & g_low), g_low};
  assign sum_d     = hp ^ {g[30:0], cin};
  assign in_fire   = in_valid & in_ready;
  assign out_valid = state != EMPTY;
`ifdef KS_SKID_EN
  logic             rdy_q;
  logic [31:0]      sk_sum;
  logic             sk_cout, sk_ovf;
  logic [TAG_W-1:0] sk_tag;
  assign in_ready = rdy_q & ~rst;
  always_comb
    nxt = state == EMPTY ? (in_fire ? HOLD1 : EMPTY) :
          state == HOLD1 ? (in_fire && !out_ready ? HOLD2 : (!in_fire && out_ready ? EMPTY : HOLD1)) :
          (out_ready ? HOLD1 : HOLD2);
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      rdy_q   <= 1'b1;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      tag_out <= '0;
      sk_sum  <= '0;
      sk_cout <= 1'b0;
      sk_ovf  <= 1'b0;
      sk_tag  <= '0;
    end else begin
      if (state == HOLD2 && out_ready) begin
        sum     <= sk_sum;
        cout    <= sk_cout;
        ovf     <= sk_ovf;
        tag_out <= sk_tag;
      end else if (in_fire && (state == EMPTY || out_ready)) begin
        sum     <= sum_d;
        cout    <= g[31];
        ovf     <= g[31] ^ g[30];
        tag_out <= tag_in;
      end
      // full output slot and downstream stalled: park the new result behind it
      if (in_fire && state == HOLD1 && !out_ready) begin
        sk_sum  <= sum_d;
        sk_cout <= g[31];
        sk_ovf  <= g[31] ^ g[30];
        sk_tag  <= tag_in;
      end
      state <= nxt;
      rdy_q <= nxt != HOLD2;
    end
  end
`else
  assign in_ready = ~rst & (~out_valid | out_ready);
  always_comb nxt = in_fire ? HOLD1 : (out_ready ? EMPTY : state);
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      tag_out <= '0;
    end else begin
      state <= nxt;
      if (in_fire) begin
        sum     <= sum_d;
        cout    <= g[31];
        ovf     <= g[31] ^ g[30];
        tag_out <= tag_in;
      end
    end
  end
`endif
endmodule

// File: tb/tb_ks_level5_sum.sv
// tb_ks_level5_sum: random and directed checks of ks_level5_sum against an arithmetic scoreboard.
module tb_ks_level5_sum;
  typedef struct packed {
    logic [3:0]  tag;
    logic        c;
    logic [31:0] b;
    logic [31:0] a;
  } op_t;
`ifdef KS_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif
  logic        clk, rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [31:16] p_list4;
  logic [31:4]  g_list4;
  logic [3:0]   g_lo, tag_in, tag_out;
  logic [31:0]  hp, sum;
  op_t          pending[$];
  logic [63:0]  exp_q[$];
  op_t          cur;
  logic         fire_in, hold_v, gap_en;
  logic [63:0]  held;
  int           n_chk, n_err, n_acc, n_out;

  ks_level5_sum #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p_list4(p_list4), .g_list4(g_list4), .g_lo(g_lo), .hp(hp), .cin(cin),
    .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .tag_out(tag_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] model(input op_t o);
    logic [32:0] s;
    logic        v;
    s = {1'b0, o.a} + {1'b0, o.b} + {32'b0, o.c};
    v = (o.a[31] == o.b[31]) && (s[31] != o.a[31]);
    return {26'b0, o.tag, v, s[32], s[31:0]};
  endfunction

  // upstream levels 0..4 producing the terms this stage consumes
  task automatic drive_op(input op_t o);
    logic [31:0] g, p, gn, pn;
    g = o.a & o.b;
    p = o.a ^ o.b;
    g[0] = g[0] | (p[0] & o.c);
    for (int d = 1; d < 16; d = d * 2) begin
      for (int i = 0; i < 32; i++) begin
        gn[i] = g[i];
        pn[i] = p[i];
        if (i >= d) begin
          gn[i] = g[i] | (p[i] & g[i-d]);
          pn[i] = p[i] & p[i-d];
        end
      end
      g = gn;
      p = pn;
    end
    p_list4 = p[31:16];
    g_list4 = g[31:4];
    g_lo    = g[3:0];
    hp      = o.a ^ o.b;
    cin     = o.c;
    tag_in  = o.tag;
  endtask

  initial begin
    in_valid = 1'b0;
    cur = '0;
    drive_op(cur);
    forever begin
      @(posedge clk);
      #1;
      if (fire_in && pending.size() > 0) pending.delete(0);
      if (pending.size() > 0) begin
        cur = pending[0];
        drive_op(cur);
        in_valid = gap_en ? ($urandom_range(3) != 0) : 1'b1;
      end else
        in_valid = 1'b0;
    end
  end

  initial begin
    fire_in = 1'b0;
    hold_v = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_in_ready", {63'b0, in_ready}, 64'd0);
        exp_q.delete();
        fire_in = 1'b0;
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("stall_valid", {63'b0, out_valid}, 64'd1);
          check("stall_data", {26'b0, tag_out, ovf, cout, sum}, held);
        end
        fire_in = in_valid && in_ready;
        if (fire_in) begin
          exp_q.push_back(model(cur));
          n_acc++;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("spurious_out", {63'b0, out_valid}, 64'd0);
          else begin
            check("result", {26'b0, tag_out, ovf, cout, sum}, exp_q.pop_front());
            n_out++;
          end
        end
        hold_v = out_valid && !out_ready;
        held = {26'b0, tag_out, ovf, cout, sum};
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic c, input logic [3:0] t);
    op_t o;
    o.a = a;
    o.b = b;
    o.c = c;
    o.tag = t;
    pending.push_back(o);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    gap_en = 1'b0;
    for (int i = 0; i < 300 && (pending.size() + exp_q.size()) != 0; i++) step(1);
    check("drain_left", 64'(pending.size() + exp_q.size()), 64'd0);
  endtask

  task automatic run_dir(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                         input logic [31:0] es, input logic ec, input logic eo);
    out_ready = 1'b0;
    push(a, b, 1'b0, t);
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    check("dir_valid", {63'b0, out_valid}, 64'd1);
    check("dir_sum", {32'b0, sum}, {32'b0, es});
    check("dir_cout", {63'b0, cout}, {63'b0, ec});
    check("dir_ovf", {63'b0, ovf}, {63'b0, eo});
    check("dir_tag", {60'b0, tag_out}, {60'b0, t});
    step(1);
    drain();
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_sum", {32'b0, sum}, 64'd0);
    check("rst_cout", {63'b0, cout}, 64'd0);
    check("rst_ovf", {63'b0, ovf}, 64'd0);
    check("rst_tag", {60'b0, tag_out}, 64'd0);
    check("rst_rdy_after", {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    int n0, o0, cyc;
    n_chk = 0; n_err = 0; n_acc = 0; n_out = 0;
    rst = 1'b1;
    out_ready = 1'b0;
    gap_en = 1'b0;
    step(3);
    rst = 1'b0;
    check_reset_state();
    step(1);

    run_dir(32'hFFFF_FFFF, 32'h0000_0001, 4'd3, 32'h0000_0000, 1'b1, 1'b0);
    run_dir(32'h7FFF_FFFF, 32'h0000_0001, 4'd5, 32'h8000_0000, 1'b0, 1'b1);
    run_dir(32'h8000_0000, 32'h8000_0000, 4'd9, 32'h0000_0000, 1'b1, 1'b1);

    out_ready = 1'b1;
    o0 = n_out;
    for (int i = 0; i < 16; i++) push($urandom, $urandom, 1'($urandom), 4'(i));
    cyc = 0;
    while (cyc < 40 && (pending.size() + exp_q.size()) != 0) begin
      step(1);
      cyc++;
    end
    check("b2b_count", 64'(n_out - o0), 64'd16);
    check("b2b_rate", 64'(cyc <= 19), 64'd1);

    out_ready = 1'b0;
    n0 = n_acc;
    o0 = n_out;
    for (int i = 0; i < 3; i++) push($urandom, $urandom, 1'($urandom), 4'(10 + i));
    step(5);
    check("stall_acc", 64'(n_acc - n0), 64'(EXP_ACC));
    check("stall_in_ready", {63'b0, in_ready}, 64'd0);
    drain();
    check("stall_drained", 64'(n_out - o0), 64'd3);

    gap_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      out_ready = 1'($urandom);
      if (pending.size() < 2) push($urandom, $urandom, 1'($urandom), 4'(i));
      step(1);
    end
    drain();
    check("rand_balance", 64'(n_acc), 64'(n_out));

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push($urandom, $urandom, 1'($urandom), 4'(i + 1));
    step(4);
    o0 = n_out;
    rst = 1'b1;
    pending.delete();
    step(2);
    rst = 1'b0;
    check_reset_state();
    step(1);
    out_ready = 1'b1;
    step(5);
    check("rst_no_out", 64'(n_out - o0), 64'd0);
    check("rst_empty", {63'b0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
